// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : icache_assoc
// Brief    : Set-associative instruction cache between the fetcher and the
//            memory controller. One 32-bit word per request, whole-line fills
//            on a miss, per-set round-robin replacement, flush squashing of a
//            pending response and invalidate-all. Requires BLOCK_WIDTH >= 1
//            and SET_WIDTH >= 1.
// Revision : 1.0 - initial release
// ============================================================================
module icache_assoc #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 2,
  parameter int SET_WIDTH   = 6,
  parameter int WAY_WIDTH   = 1
) (
  input  logic                              Sys_clk,
  input  logic                              Sys_rst,
  input  logic                              Sys_rdy,
  input  logic                              IFIC_en,
  input  logic [ADDR_WIDTH-1:0]             IFIC_addr,
  output logic                              ICIF_en,
  output logic [31:0]                       ICIF_data,
  input  logic                              Flush,
  input  logic                              Inv,
  output logic                              ICMC_en,
  output logic [ADDR_WIDTH-1:0]             ICMC_addr,
  input  logic                              MCIC_en,
  input  logic [32*(2**BLOCK_WIDTH)-1:0]    MCIC_block
);

  localparam int c_BLOCK_SIZE = 2**BLOCK_WIDTH;
  localparam int c_SET_NUM    = 2**SET_WIDTH;
  localparam int c_WAYS       = 2**WAY_WIDTH;
  localparam int c_IDX_LSB    = BLOCK_WIDTH + 2;
  localparam int c_TAG_LSB    = BLOCK_WIDTH + SET_WIDTH + 2;
  localparam int c_TAG_W      = ADDR_WIDTH - c_TAG_LSB;
  localparam int c_LINE_W     = 32 * c_BLOCK_SIZE;
  localparam int c_RRW        = (WAY_WIDTH > 0) ? WAY_WIDTH : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MISS = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                  r_state;
  logic                    r_valid [c_WAYS][c_SET_NUM];
  logic [c_TAG_W-1:0]      r_tag   [c_WAYS][c_SET_NUM];
  logic [c_LINE_W-1:0]     r_line  [c_WAYS][c_SET_NUM];
  logic [c_RRW-1:0]        r_rr    [c_SET_NUM];
  logic [ADDR_WIDTH-1:0]   r_miss_addr;
  logic                    r_inv_pend;
  logic                    r_icif_en;
  logic [31:0]             r_icif_data;
  logic                    r_icmc_en;
  logic [ADDR_WIDTH-1:0]   r_icmc_addr;

  logic [BLOCK_WIDTH-1:0]  w_req_off, w_miss_off;
  logic [SET_WIDTH-1:0]    w_req_idx, w_miss_idx;
  logic [c_TAG_W-1:0]      w_req_tag, w_miss_tag;
  logic                    w_hit;
  logic [31:0]             w_hit_word;
  logic                    w_found;
  logic [c_RRW-1:0]        w_victim;
  logic [c_RRW-1:0]        w_rr_next;
  logic [31:0]             w_fill_word;
  logic                    w_fill;
  logic                    w_unused_ok;

  assign w_req_off   = IFIC_addr[c_IDX_LSB-1:2];
  assign w_req_idx   = IFIC_addr[c_TAG_LSB-1:c_IDX_LSB];
  assign w_req_tag   = IFIC_addr[ADDR_WIDTH-1:c_TAG_LSB];
  assign w_miss_off  = r_miss_addr[c_IDX_LSB-1:2];
  assign w_miss_idx  = r_miss_addr[c_TAG_LSB-1:c_IDX_LSB];
  assign w_miss_tag  = r_miss_addr[ADDR_WIDTH-1:c_TAG_LSB];
  assign w_fill_word = 32'(MCIC_block >> {w_miss_off, 5'b0});
  assign w_rr_next   = (r_rr[w_miss_idx] == c_RRW'(c_WAYS - 1)) ? '0 : r_rr[w_miss_idx] + 1'b1;
  assign w_fill      = Sys_rst && Sys_rdy && MCIC_en && (r_state == S_MISS || r_state == S_DRAIN);
  assign w_unused_ok = ^{IFIC_addr[1:0], r_miss_addr[1:0]};

  assign ICIF_en   = r_icif_en;
  assign ICIF_data = r_icif_data;
  assign ICMC_en   = r_icmc_en;
  assign ICMC_addr = r_icmc_addr;

  // Tag compare across all ways of the requested set and word select on hit
  always_comb begin
    w_hit      = 1'b0;
    w_hit_word = '0;
    for (int w = 0; w < c_WAYS; w++) begin
      if (r_valid[w][w_req_idx] && (r_tag[w][w_req_idx] == w_req_tag)) begin
        w_hit      = 1'b1;
        w_hit_word = 32'(r_line[w][w_req_idx] >> {w_req_off, 5'b0});
      end
    end
  end

  // Victim choice: lowest-index invalid way, otherwise the round-robin way
  always_comb begin
    w_found  = 1'b0;
    w_victim = r_rr[w_miss_idx];
    for (int w = 0; w < c_WAYS; w++) begin
      if (!w_found && !r_valid[w][w_miss_idx]) begin
        w_found  = 1'b1;
        w_victim = c_RRW'(w);
      end
    end
  end

  // Line storage: tag and data are written only when a fill lands
  always_ff @(posedge Sys_clk) begin
    if (w_fill) begin
      r_tag[w_victim][w_miss_idx]  <= w_miss_tag;
      r_line[w_victim][w_miss_idx] <= MCIC_block;
    end
  end

  // Control FSM, valid bits, replacement pointers and registered outputs
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst) begin
      r_state     <= S_IDLE;
      r_miss_addr <= '0;
      r_inv_pend  <= 1'b0;
      r_icif_en   <= 1'b0;
      r_icif_data <= '0;
      r_icmc_en   <= 1'b0;
      r_icmc_addr <= '0;
      for (int s = 0; s < c_SET_NUM; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < c_WAYS; w++) r_valid[w][s] <= 1'b0;
      end
    end else if (Sys_rdy) begin
      r_icif_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Inv) begin
            for (int s = 0; s < c_SET_NUM; s++)
              for (int w = 0; w < c_WAYS; w++) r_valid[w][s] <= 1'b0;
          end else if (IFIC_en && !Flush) begin
            if (w_hit) begin
              r_icif_en   <= 1'b1;
              r_icif_data <= w_hit_word;
            end else begin
              r_miss_addr <= IFIC_addr;
              r_icmc_addr <= {IFIC_addr[ADDR_WIDTH-1:c_IDX_LSB], {c_IDX_LSB{1'b0}}};
              r_icmc_en   <= 1'b1;
              r_state     <= S_MISS;
            end
          end
        end
        S_MISS, S_DRAIN: begin
          if (MCIC_en) begin
            r_valid[w_victim][w_miss_idx] <= 1'b1;
            if (w_victim == r_rr[w_miss_idx]) r_rr[w_miss_idx] <= w_rr_next;
            r_icmc_en <= 1'b0;
            if (r_state == S_MISS && !Flush) begin
              r_icif_en   <= 1'b1;
              r_icif_data <= w_fill_word;
            end
            // A pending invalidate wipes everything, including the new line
            if (r_inv_pend || Inv) begin
              for (int s = 0; s < c_SET_NUM; s++)
                for (int w = 0; w < c_WAYS; w++) r_valid[w][s] <= 1'b0;
            end
            r_inv_pend <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            if (Inv) r_inv_pend <= 1'b1;
            if (r_state == S_MISS && Flush) r_state <= S_DRAIN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_assoc
// Brief    : Scoreboard bench for icache_assoc (2-way, 64 sets, 16B lines).
//            A reference cache model predicts hit/miss and response words;
//            a monitor pops expected words whenever ICIF_en pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_assoc;

  logic         clk = 1'b0;
  logic         rst_n, rdy, ific_en, flush, inv, mcic_en;
  logic [31:0]  ific_addr;
  logic         icif_en, icmc_en;
  logic [31:0]  icif_data, icmc_addr;
  logic [127:0] mcic_block;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q [$];

  // Reference model: per set/way valid, tag and line, per-set round-robin
  bit           m_valid [2][64];
  logic [21:0]  m_tag   [2][64];
  logic [127:0] m_line  [2][64];
  int           m_rr    [64];

  icache_assoc #(.ADDR_WIDTH(32), .BLOCK_WIDTH(2), .SET_WIDTH(6), .WAY_WIDTH(1)) dut (
    .Sys_clk(clk), .Sys_rst(rst_n), .Sys_rdy(rdy),
    .IFIC_en(ific_en), .IFIC_addr(ific_addr),
    .ICIF_en(icif_en), .ICIF_data(icif_data),
    .Flush(flush), .Inv(inv),
    .ICMC_en(icmc_en), .ICMC_addr(icmc_addr),
    .MCIC_en(mcic_en), .MCIC_block(mcic_block)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [31:0] a);
    return blk[32*a[3:2] +: 32];
  endfunction

  task automatic m_lookup(input logic [31:0] a, output bit hit, output logic [31:0] word);
    hit  = 1'b0;
    word = '0;
    for (int w = 0; w < 2; w++)
      if (m_valid[w][a[9:4]] && m_tag[w][a[9:4]] == a[31:10]) begin
        hit  = 1'b1;
        word = word_of(m_line[w][a[9:4]], a);
      end
  endtask

  task automatic m_install(input logic [31:0] a, input logic [127:0] blk);
    int s, v;
    s = int'(a[9:4]);
    v = -1;
    for (int w = 1; w >= 0; w--) if (!m_valid[w][s]) v = w;
    if (v < 0) v = m_rr[s];
    if (v == m_rr[s]) m_rr[s] = (m_rr[s] + 1) % 2;
    m_valid[v][s] = 1'b1;
    m_tag[v][s]   = a[31:10];
    m_line[v][s]  = blk;
  endtask

  task automatic m_clear();
    for (int s = 0; s < 64; s++) begin
      m_valid[0][s] = 1'b0;
      m_valid[1][s] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 plain, 1 flush one cycle after miss, 2 invalidate during miss,
  //       3 Sys_rdy low for 3 cycles with MCIC_en held
  task automatic fetch(input logic [31:0] a, input logic [127:0] blk, input int mode);
    bit hit;
    logic [31:0] w;
    bit resp;
    int dly;
    m_lookup(a, hit, w);
    ific_en   = 1'b1;
    ific_addr = a;
    if (hit) exp_q.push_back(w);
    tick();
    if (hit) begin
      chk("hit_resp_en", {31'd0, icif_en}, 32'd1);
      chk("hit_no_mc", {31'd0, icmc_en}, 32'd0);
      ific_en = 1'b0;
    end else begin
      chk("miss_mc_en", {31'd0, icmc_en}, 32'd1);
      chk("miss_mc_addr", icmc_addr, {a[31:4], 4'h0});
      resp = 1'b1;
      if (mode == 1) begin
        flush = 1'b1;
        tick();
        flush   = 1'b0;
        ific_en = 1'b0;
        resp    = 1'b0;
        for (int i = 0; i < 4; i++) tick();
      end else if (mode == 2) begin
        inv = 1'b1;
        tick();
        inv = 1'b0;
      end else if (mode == 3) begin
        rdy        = 1'b0;
        mcic_en    = 1'b1;
        mcic_block = blk;
        for (int i = 0; i < 3; i++) begin
          tick();
          chk("stall_mc_en", {31'd0, icmc_en}, 32'd1);
          chk("stall_no_resp", {31'd0, icif_en}, 32'd0);
        end
        rdy = 1'b1;
      end else begin
        dly = $urandom_range(0, 3);
        for (int i = 0; i < dly; i++) tick();
      end
      chk("mc_addr_hold", icmc_addr, {a[31:4], 4'h0});
      mcic_en    = 1'b1;
      mcic_block = blk;
      m_install(a, blk);
      if (resp) exp_q.push_back(word_of(blk, a));
      tick();
      mcic_en = 1'b0;
      chk("fill_mc_drop", {31'd0, icmc_en}, 32'd0);
      chk("fill_resp_en", {31'd0, icif_en}, {31'd0, resp});
      if (mode == 2) m_clear();
      ific_en = 1'b0;
    end
    tick();
  endtask

  // Monitor: every response pulse must match the oldest expected word
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && icif_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_resp: got ICIF_en=1 data 0x%08h expected no response at %0t", icif_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", icif_data, e);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    bit hit;
    logic [31:0] w;
    int r, mode;
    rst_n = 1'b0; rdy = 1'b1; ific_en = 1'b0; ific_addr = '0;
    flush = 1'b0; inv = 1'b0; mcic_en = 1'b0; mcic_block = '0;
    m_clear();
    for (int s = 0; s < 64; s++) m_rr[s] = 0;
    tick(); tick();
    chk("rst_icif_en", {31'd0, icif_en}, 32'd0);
    chk("rst_icif_data", icif_data, 32'd0);
    chk("rst_icmc_en", {31'd0, icmc_en}, 32'd0);
    chk("rst_icmc_addr", icmc_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed scenarios
    fetch(32'h100, {32'h4, 32'h3, 32'h2, 32'h1}, 0);
    fetch(32'h108, '0, 0);
    fetch(32'h000, {4{32'hA0A0_0000}} ^ 128'h3_00000002_00000001_00000000, 0);
    fetch(32'h400, {4{32'hB1B1_0000}} ^ 128'h3_00000002_00000001_00000000, 0);
    fetch(32'h800, {4{32'hC2C2_0000}} ^ 128'h3_00000002_00000001_00000000, 0);
    fetch(32'h404, '0, 0);
    fetch(32'h000, {4{32'hD3D3_0000}}, 0);
    fetch(32'h200, {32'h2C, 32'h2B, 32'h2A, 32'h29}, 1);
    fetch(32'h20C, '0, 0);
    fetch(32'h300, {32'h3D, 32'h3C, 32'h3B, 32'h3A}, 2);
    fetch(32'h300, {32'h4D, 32'h4C, 32'h4B, 32'h4A}, 0);
    fetch(32'h100, {32'h5D, 32'h5C, 32'h5B, 32'h5A}, 0);
    fetch(32'h508, {32'h6D, 32'h6C, 32'h6B, 32'h6A}, 3);

    // Flush coinciding with a would-be hit: no response, no fill request
    ific_en = 1'b1; ific_addr = 32'h104; flush = 1'b1;
    tick();
    ific_en = 1'b0; flush = 1'b0;
    chk("flush_hit_no_resp", {31'd0, icif_en}, 32'd0);
    chk("flush_hit_no_mc", {31'd0, icmc_en}, 32'd0);
    tick();

    // Invalidate in idle, then a previously cached line must miss
    inv = 1'b1;
    tick();
    inv = 1'b0;
    m_clear();
    fetch(32'h104, {32'h7D, 32'h7C, 32'h7B, 32'h7A}, 0);

    // Randomised traffic over a small address pool to force hits and conflicts
    for (int n = 0; n < 250; n++) begin
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      r = $urandom_range(0, 19);
      mode = (r < 14) ? 0 : (r < 16) ? 1 : (r < 18) ? 2 : 3;
      if (r == 19) begin
        inv = 1'b1;
        tick();
        inv = 1'b0;
        m_clear();
      end else begin
        m_lookup(a, hit, w);
        fetch(a, {$urandom, $urandom, $urandom, $urandom}, mode);
      end
    end

    tick(); tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
